// File: rtl/teclado_pkg.sv
// Shared key codes, FSM encoding and helpers for the
// password-entry stage.
package teclado_pkg;

    localparam logic [3:0] TECLA_BORRAR = 4'hE;
    localparam logic [3:0] TECLA_ENTER  = 4'hF;

    typedef enum logic [1:0] {
        CAPTURA   = 2'd0,
        VERIFICAR = 2'd1,
        BLOQUEO   = 2'd2
    } estado_t;

    function automatic logic es_digito(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/contador_bloqueo.sv
// Lockout down-counter: loads LOCK_CYCLES-1, counts to zero,
// flags zero.
module contador_bloqueo #(
    parameter int LOCK_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic cargar,
    input  logic contar,
    output logic cero
);

    localparam int W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [W-1:0] INICIO = W'(LOCK_CYCLES - 1);

    logic [W-1:0] cuenta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cuenta <= '0;
        end else if (cargar) begin
            cuenta <= INICIO;
        end else if (contar && cuenta != '0) begin
            cuenta <= cuenta - 1'b1;
        end
    end

    assign cero = (cuenta == '0);

endmodule

// File: rtl/verificador_clave.sv
// Password-entry stage: buffers keypad digits, verifies on '#',
// locks out after repeated failures.
module verificador_clave
    import teclado_pkg::*;
#(
    parameter int              DIGITS       = 4,
    parameter logic [4*DIGITS-1:0] CLAVE    = 16'h1234,
    parameter int              MAX_INTENTOS = 3,
    parameter int              LOCK_CYCLES  = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          tecla,
    input  logic                tecla_valida,
    output logic [4*DIGITS-1:0] digitos,
    output logic [3:0]          n_digitos,
    output logic                acceso_ok,
    output logic                acceso_negado,
    output logic                bloqueado,
    output logic [3:0]          intentos
);

    localparam int DW = 4 * DIGITS;

    estado_t       estado, estado_sig;
    logic [DW-1:0] digitos_sig;
    logic [3:0]    n_sig, int_sig;
    logic          ok_sig, neg_sig, bloq_sig;
    logic          cargar, contar, cero, coincide;

    contador_bloqueo #(.LOCK_CYCLES(LOCK_CYCLES)) u_contador (
        .clk    (clk),
        .rst    (rst),
        .cargar (cargar),
        .contar (contar),
        .cero   (cero)
    );

    assign coincide = (n_digitos == 4'(DIGITS)) && (digitos == CLAVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado        <= CAPTURA;
            digitos       <= '0;
            n_digitos     <= '0;
            acceso_ok     <= 1'b0;
            acceso_negado <= 1'b0;
            bloqueado     <= 1'b0;
            intentos      <= '0;
        end else begin
            estado        <= estado_sig;
            digitos       <= digitos_sig;
            n_digitos     <= n_sig;
            acceso_ok     <= ok_sig;
            acceso_negado <= neg_sig;
            bloqueado     <= bloq_sig;
            intentos      <= int_sig;
        end
    end

    always_comb begin
        estado_sig  = estado;
        digitos_sig = digitos;
        n_sig       = n_digitos;
        ok_sig      = 1'b0;
        neg_sig     = 1'b0;
        bloq_sig    = bloqueado;
        int_sig     = intentos;
        cargar      = 1'b0;
        contar      = 1'b0;
        unique case (estado)
            CAPTURA: begin
                if (tecla_valida) begin
                    if (es_digito(tecla)) begin
                        if (n_digitos < 4'(DIGITS)) begin
                            digitos_sig = (digitos << 4) | DW'(tecla);
                            n_sig       = n_digitos + 4'd1;
                        end
                    end else if (tecla == TECLA_BORRAR) begin
                        digitos_sig = '0;
                        n_sig       = '0;
                    end else if (tecla == TECLA_ENTER) begin
                        estado_sig = VERIFICAR;
                    end
                end
            end
            VERIFICAR: begin
                digitos_sig = '0;
                n_sig       = '0;
                estado_sig  = CAPTURA;
                if (coincide) begin
                    ok_sig  = 1'b1;
                    int_sig = '0;
                end else begin
                    neg_sig = 1'b1;
                    if (int'(intentos) + 1 < MAX_INTENTOS) begin
                        int_sig = intentos + 4'd1;
                    end else begin
                        int_sig    = '0;
                        bloq_sig   = 1'b1;
                        cargar     = 1'b1;
                        estado_sig = BLOQUEO;
                    end
                end
            end
            BLOQUEO: begin
                // bloqueado falls in the cycle the timer reads zero
                contar = 1'b1;
                if (cero) begin
                    estado_sig = CAPTURA;
                    bloq_sig   = 1'b0;
                end
            end
            default: estado_sig = CAPTURA;
        endcase
    end

endmodule

// File: tb/tb_verificador_clave.sv
// Directed bench for verificador_clave with a short lockout.
module tb_verificador_clave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  tecla = 4'h0;
    logic        tecla_valida = 1'b0;
    logic [15:0] digitos;
    logic [3:0]  n_digitos;
    logic        acceso_ok, acceso_negado, bloqueado;
    logic [3:0]  intentos;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    verificador_clave #(.LOCK_CYCLES(20)) dut (
        .clk           (clk),
        .rst           (rst),
        .tecla         (tecla),
        .tecla_valida  (tecla_valida),
        .digitos       (digitos),
        .n_digitos     (n_digitos),
        .acceso_ok     (acceso_ok),
        .acceso_negado (acceso_negado),
        .bloqueado     (bloqueado),
        .intentos      (intentos)
    );

    task automatic revisar(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulsar(input logic [3:0] k);
        @(posedge clk); #1;
        tecla = k;
        tecla_valida = 1'b1;
        @(posedge clk); #1;
        tecla_valida = 1'b0;
    endtask

    task automatic tecla_sep(input logic [3:0] k);
        pulsar(k);
        repeat (2) @(posedge clk);
    endtask

    task automatic clave(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) tecla_sep(v[4*i +: 4]);
    endtask

    task automatic enter(input string tag, input logic ok, input logic neg);
        pulsar(4'hF);
        revisar({tag, "_t1"}, {acceso_ok, acceso_negado}, 2'b00);
        @(posedge clk); #1;
        revisar({tag, "_t2"}, {acceso_ok, acceso_negado}, {ok, neg});
        revisar({tag, "_clr"}, {n_digitos, digitos}, 20'h0);
        @(posedge clk); #1;
        revisar({tag, "_t3"}, {acceso_ok, acceso_negado}, 2'b00);
    endtask

    task automatic lockout(input string tag);
        int n = 0, pulsos = 0, sucio = 0;
        logic [3:0] ks [5];
        ks = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF};
        while (bloqueado && n < 100) begin
            n++;
            if (n % 3 == 2 && n < 16) begin
                tecla = ks[(n - 2) / 3];
                tecla_valida = 1'b1;
            end
            @(posedge clk); #1;
            tecla_valida = 1'b0;
            if (acceso_ok || acceso_negado) pulsos++;
            if (digitos != 0) sucio++;
        end
        revisar({tag, "_len"}, n, 20);
        revisar({tag, "_pulsos"}, pulsos, 0);
        revisar({tag, "_dig"}, sucio, 0);
    endtask

    initial begin
        #1;
        revisar("rst_async", {digitos, n_digitos, acceso_ok, acceso_negado,
                bloqueado, intentos}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        revisar("rst_out", {digitos, n_digitos, acceso_ok, acceso_negado,
                bloqueado, intentos}, 0);

        // 1: correct entry
        clave(16'h1234, 4);
        revisar("t1_dig", digitos, 16'h1234);
        revisar("t1_n", n_digitos, 4);
        enter("t1", 1'b1, 1'b0);
        revisar("t1_int", intentos, 0);

        // 2: overflow and clear
        clave(16'h1234, 4);
        tecla_sep(4'h5);
        revisar("t2_ovf", digitos, 16'h1234);
        revisar("t2_ovf_n", n_digitos, 4);
        tecla_sep(4'hE);
        revisar("t2_clr", {digitos, n_digitos}, 0);
        tecla_sep(4'h9);
        revisar("t2_nine", {digitos, n_digitos}, {16'h0009, 4'd1});
        enter("t2", 1'b0, 1'b1);
        revisar("t2_int", intentos, 1);

        // 3: lockout
        clave(16'h1234, 4);
        enter("t3_ok", 1'b1, 1'b0);
        revisar("t3_int0", intentos, 0);
        clave(16'h1111, 4);
        enter("t3_a", 1'b0, 1'b1);
        revisar("t3_int1", intentos, 1);
        clave(16'h1111, 4);
        enter("t3_b", 1'b0, 1'b1);
        revisar("t3_int2", intentos, 2);
        clave(16'h1111, 4);
        pulsar(4'hF);
        @(posedge clk); #1;
        revisar("t3_c", {acceso_ok, acceso_negado}, 2'b01);
        revisar("t3_lock", {bloqueado, intentos}, {1'b1, 4'd0});
        lockout("t3");
        revisar("t3_free", {bloqueado, digitos, n_digitos}, 0);

        // 4: success resets count
        clave(16'h1111, 4);
        enter("t4_a", 1'b0, 1'b1);
        revisar("t4_int1", intentos, 1);
        clave(16'h1234, 4);
        enter("t4_ok", 1'b1, 1'b0);
        revisar("t4_int0", intentos, 0);
        clave(16'h4321, 4);
        enter("t4_b", 1'b0, 1'b1);
        clave(16'h0034, 2);
        enter("t4_c", 1'b0, 1'b1);
        revisar("t4_nolock", {bloqueado, intentos}, {1'b0, 4'd2});

        // 5: ignored keys, verify-cycle drop
        clave(16'h1234, 4);
        enter("t5_ok", 1'b1, 1'b0);
        clave(16'hABCD, 4);
        revisar("t5_ign", {digitos, n_digitos}, 0);
        pulsar(4'hF);
        tecla = 4'h5;
        tecla_valida = 1'b1;
        @(posedge clk); #1;
        tecla_valida = 1'b0;
        revisar("t5_neg", {acceso_ok, acceso_negado}, 2'b01);
        revisar("t5_drop", {digitos, n_digitos}, 0);
        @(posedge clk); #1;
        revisar("t5_drop2", {digitos, n_digitos}, 0);

        // 6: async reset mid-lockout
        clave(16'h1234, 4);
        enter("t6_ok", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            clave(16'h1111, 4);
            pulsar(4'hF);
            @(posedge clk); #1;
        end
        revisar("t6_lock", bloqueado, 1);
        repeat (6) @(posedge clk);
        #1;
        revisar("t6_still", bloqueado, 1);
        #2 rst = 1'b1;
        #1;
        revisar("t6_rst", {digitos, n_digitos, acceso_ok, acceso_negado,
                bloqueado, intentos}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        revisar("t6_nopulse", {acceso_ok, acceso_negado, bloqueado}, 0);
        clave(16'h1234, 4);
        enter("t6_ok2", 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
